// File: rtl/cmd_sequencer_if.sv
// Bundle between cmd_sequencer and its host/loader and comm-block neighbours.
// Latency: none, wires only.
// Backpressure: carried by the signals themselves (full, cmd_sent, resp_rdy).
interface cmd_sequencer_if #(
    parameter int CMD_W  = 16,
    parameter int RESP_W = 8,
    parameter int CNT_W  = 5
);
    // host / loader side
    logic              wr_cmd;
    logic [CMD_W-1:0]  wr_data;
    logic              full;
    logic              empty;
    logic              start;
    logic              abort;
    // comm block side
    logic [CMD_W-1:0]  cmd;
    logic              send_cmd;
    logic              cmd_sent;
    logic              resp_rdy;
    logic [RESP_W-1:0] resp;
    // run status
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [CNT_W-1:0]  err_idx;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  fail_cnt;

    // The sequencer itself
    modport master (
        input  wr_cmd, wr_data, start, abort, cmd_sent, resp_rdy, resp,
        output full, empty, cmd, send_cmd, busy, done, err, err_code,
               err_idx, pass_cnt, fail_cnt
    );

    // Whatever surrounds the sequencer (host, loader, comm block model)
    modport slave (
        output wr_cmd, wr_data, start, abort, cmd_sent, resp_rdy, resp,
        input  full, empty, cmd, send_cmd, busy, done, err, err_code,
               err_idx, pass_cnt, fail_cnt
    );
endinterface

// File: rtl/cmd_sequencer.sv
// Command-script engine: queues commands, issues them one by one, checks each ack, enforces a timeout.
// Latency: start -> send_cmd 1 cycle; resp_rdy -> next send_cmd 1 cycle; timeout logged TO_CYC cycles after send_cmd.
// Backpressure: pushes while full are dropped; issue is paced by cmd_sent/resp_rdy from the comm block.
module cmd_sequencer #(
    parameter int                CMD_W       = 16,
    parameter int                RESP_W      = 8,
    parameter int                DEPTH       = 16,
    parameter logic [RESP_W-1:0] EXP_RESP    = 8'hA5,
    parameter logic [23:0]       TO_CYC      = 24'd10_000_000,
    parameter bit                STOP_ON_ERR = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    cmd_sequencer_if.master    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_SENT,
        WAIT_RESP,
        FINISH
    } state_t;

    // ---------------------------------------------------------------
    // Command queue
    // ---------------------------------------------------------------
    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [CMD_W-1:0] w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // abort flushes the queue, so a write in the same cycle must not land
    assign w_push  = bus.wr_cmd && !w_full && !bus.abort;
    assign w_head  = r_mem[r_rd_ptr];

    // Storage array; stale contents are unreachable once pointers reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------
    state_t           r_state;
    state_t           w_nxt_state;

    logic [CMD_W-1:0] r_cmd;
    logic             r_send_cmd;
    logic [23:0]      r_to_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_err_code;
    logic [CW-1:0]    r_err_idx;
    logic [CW-1:0]    r_pass_cnt;
    logic [CW-1:0]    r_fail_cnt;

    logic             w_run_clr;
    logic             w_pass;
    logic             w_fail;
    logic [1:0]       w_fail_code;
    logic             w_done;
    logic             w_to_hit;
    logic             w_waiting;

    assign w_waiting = (r_state == WAIT_SENT) || (r_state == WAIT_RESP);
    // counter is 0 in the send_cmd cycle, so this fires TO_CYC-1 cycles later
    assign w_to_hit  = w_waiting && (r_to_cnt == (TO_CYC - 24'd1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next state and per-cycle control; the pop happens on entry to ISSUE so cmd is valid with send_cmd
    always_comb begin
        w_nxt_state = r_state;
        w_pop       = 1'b0;
        w_run_clr   = 1'b0;
        w_pass      = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = 2'b00;
        w_done      = 1'b0;

        case (r_state)
            IDLE: begin
                if (!bus.abort && bus.start) begin
                    if (!w_empty) begin
                        w_run_clr   = 1'b1;
                        w_pop       = 1'b1;
                        w_nxt_state = ISSUE;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            ISSUE: begin
                w_nxt_state = WAIT_SENT;
            end
            WAIT_SENT, WAIT_RESP: begin
                if ((r_state == WAIT_SENT) && bus.cmd_sent) begin
                    w_nxt_state = WAIT_RESP;
                end
                if (bus.resp_rdy || w_to_hit) begin
                    // a response on the timeout cycle takes precedence
                    if (bus.resp_rdy) begin
                        if (bus.resp == EXP_RESP) begin
                            w_pass = 1'b1;
                        end else begin
                            w_fail      = 1'b1;
                            w_fail_code = 2'b01;
                        end
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = 2'b10;
                    end
                    if (STOP_ON_ERR && w_fail) begin
                        w_nxt_state = FINISH;
                    end else if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_nxt_state = ISSUE;
                    end else begin
                        w_nxt_state = FINISH;
                    end
                end
            end
            FINISH: begin
                w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase

        // abort ends an active run immediately; a same-cycle response is not logged
        if (bus.abort && (r_state != IDLE) && (r_state != FINISH)) begin
            w_nxt_state = FINISH;
            w_pop       = 1'b0;
            w_pass      = 1'b0;
            w_fail      = 1'b0;
            w_fail_code = 2'b00;
        end

        if ((w_nxt_state == FINISH) && (r_state != FINISH)) begin
            w_done = 1'b1;
        end
    end

    // Issue register: command word and one-cycle send strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd      <= '0;
            r_send_cmd <= 1'b0;
        end else begin
            r_send_cmd <= w_pop;
            if (w_pop) begin
                r_cmd <= w_head;
            end
        end
    end

    // Response timeout counter, restarted for every issued command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_pop) begin
            r_to_cnt <= '0;
        end else if ((r_state == ISSUE) || w_waiting) begin
            r_to_cnt <= r_to_cnt + 24'd1;
        end
    end

    // Run status: busy, done pulse, counters and first-error capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_err_idx  <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_done <= w_done;
            if (w_run_clr) begin
                r_busy <= 1'b1;
            end else if (w_nxt_state == FINISH) begin
                r_busy <= 1'b0;
            end

            if (w_run_clr) begin
                r_err      <= 1'b0;
                r_err_code <= 2'b00;
                r_err_idx  <= '0;
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
            end else begin
                if (w_pass) begin
                    r_pass_cnt <= r_pass_cnt + 1'b1;
                end
                if (w_fail) begin
                    r_fail_cnt <= r_fail_cnt + 1'b1;
                    // only the first failure of a run is recorded in detail
                    if (!r_err) begin
                        r_err      <= 1'b1;
                        r_err_code <= w_fail_code;
                        r_err_idx  <= r_pass_cnt + r_fail_cnt;
                    end
                end
            end
        end
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.cmd      = r_cmd;
    assign bus.send_cmd = r_send_cmd;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.err_code = r_err_code;
    assign bus.err_idx  = r_err_idx;
    assign bus.pass_cnt = r_pass_cnt;
    assign bus.fail_cnt = r_fail_cnt;
endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: two instances (halt-on-error and log-and-continue) share stimulus.
// Latency: checks exact start->send_cmd and send_cmd->timeout cycle counts.
// Backpressure: exercises queue full/drop, abort flush and a slow responder.
module tb_cmd_sequencer;
    logic        clk;
    logic        rst_n;
    logic        wr_cmd;
    logic [15:0] wr_data;
    logic        start;
    logic        abort;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    int n_chk = 0;
    int n_err = 0;

    // responder configuration: mode 0 = ack from table at t=3, mode 1 = A5 at t=rsp_late
    int          rsp_mode;
    int          rsp_late;
    int          rsp_t = -1;
    logic [7:0]  rsp_tab [32];

    logic [15:0] iss_log [$];
    int          b_iss  = 0;
    int          a_done = 0;

    cmd_sequencer_if #(.CMD_W(16), .RESP_W(8), .CNT_W(5)) a_if ();
    cmd_sequencer_if #(.CMD_W(16), .RESP_W(8), .CNT_W(5)) b_if ();

    assign a_if.wr_cmd   = wr_cmd;
    assign a_if.wr_data  = wr_data;
    assign a_if.start    = start;
    assign a_if.abort    = abort;
    assign a_if.cmd_sent = cmd_sent;
    assign a_if.resp_rdy = resp_rdy;
    assign a_if.resp     = resp;
    assign b_if.wr_cmd   = wr_cmd;
    assign b_if.wr_data  = wr_data;
    assign b_if.start    = start;
    assign b_if.abort    = abort;
    assign b_if.cmd_sent = cmd_sent;
    assign b_if.resp_rdy = resp_rdy;
    assign b_if.resp     = resp;

    cmd_sequencer #(
        .CMD_W(16), .RESP_W(8), .DEPTH(16), .EXP_RESP(8'hA5),
        .TO_CYC(24'd100), .STOP_ON_ERR(1'b1)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.master)
    );

    cmd_sequencer #(
        .CMD_W(16), .RESP_W(8), .DEPTH(16), .EXP_RESP(8'hA5),
        .TO_CYC(24'd100), .STOP_ON_ERR(1'b0)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // comm-block model, keyed on instance B (it issues a superset of A's commands)
    always @(negedge clk) begin
        if (b_if.send_cmd) begin
            rsp_t = 0;
        end else if (rsp_t >= 0) begin
            rsp_t = rsp_t + 1;
        end
        cmd_sent = (rsp_t == 2);
        if ((rsp_t >= 0) && (rsp_t == ((rsp_mode == 0) ? 3 : rsp_late))) begin
            resp_rdy = 1'b1;
            resp     = (rsp_mode == 0) ? rsp_tab[(int'(b_if.pass_cnt) + int'(b_if.fail_cnt)) & 31] : 8'hA5;
            rsp_t    = -1;
        end else begin
            resp_rdy = 1'b0;
            resp     = 8'h00;
        end
    end

    // monitor: log A's issued commands and done pulses, count B's issues
    always @(negedge clk) begin
        if (a_if.send_cmd) iss_log.push_back(a_if.cmd);
        if (a_if.done)     a_done = a_done + 1;
        if (b_if.send_cmd) b_iss  = b_iss + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] iss(input int i);
        return (i < iss_log.size()) ? iss_log[i] : 16'hBAD0;
    endfunction

    task automatic push(input logic [15:0] d);
        wr_cmd  = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_cmd  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic flush();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((a_if.busy || b_if.busy) && (n < 3000)) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_bound"}, 32'(n < 3000), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        int d0;
        int bb;
        int n;
        rst_n    = 1'b0;
        wr_cmd   = 1'b0;
        wr_data  = '0;
        start    = 1'b0;
        abort    = 1'b0;
        rsp_mode = 0;
        rsp_late = -1;
        for (int i = 0; i < 32; i++) rsp_tab[i] = 8'hA5;
        repeat (2) @(negedge clk);

        // ---- reset state
        chk("rst_empty",    a_if.empty,    1);
        chk("rst_full",     a_if.full,     0);
        chk("rst_cmd",      a_if.cmd,      0);
        chk("rst_send",     a_if.send_cmd, 0);
        chk("rst_busy",     a_if.busy,     0);
        chk("rst_done",     a_if.done,     0);
        chk("rst_err",      a_if.err,      0);
        chk("rst_err_code", a_if.err_code, 0);
        chk("rst_err_idx",  a_if.err_idx,  0);
        chk("rst_pass",     a_if.pass_cnt, 0);
        chk("rst_fail",     a_if.fail_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- three good commands
        push(16'h0000); push(16'h4000); push(16'h23FF);
        chk("t1_empty_pre", a_if.empty, 0);
        base = iss_log.size();
        d0   = a_done;
        pulse_start();
        chk("t1_lat_send", a_if.send_cmd, 1);
        chk("t1_lat_busy", a_if.busy, 1);
        wait_idle("t1");
        chk("t1_n_issued", iss_log.size() - base, 3);
        chk("t1_cmd0", iss(base),     16'h0000);
        chk("t1_cmd1", iss(base + 1), 16'h4000);
        chk("t1_cmd2", iss(base + 2), 16'h23FF);
        chk("t1_pass",  a_if.pass_cnt, 3);
        chk("t1_fail",  a_if.fail_cnt, 0);
        chk("t1_err",   a_if.err, 0);
        chk("t1_done",  a_done - d0, 1);
        chk("t1_empty", a_if.empty, 1);
        chk("t1_b_pass", b_if.pass_cnt, 3);

        // ---- bad ack on the 2nd of 4: A halts, B continues
        rsp_tab[1] = 8'h5A;
        push(16'h0011); push(16'h0022); push(16'h0033); push(16'h0044);
        base = iss_log.size();
        d0   = a_done;
        bb   = b_iss;
        pulse_start();
        wait_idle("t2");
        chk("t2_a_pass",  a_if.pass_cnt, 1);
        chk("t2_a_fail",  a_if.fail_cnt, 1);
        chk("t2_a_err",   a_if.err, 1);
        chk("t2_a_code",  a_if.err_code, 2'b01);
        chk("t2_a_idx",   a_if.err_idx, 1);
        chk("t2_a_empty", a_if.empty, 0);
        chk("t2_a_issued", iss_log.size() - base, 2);
        chk("t2_a_done",  a_done - d0, 1);
        chk("t2_b_pass",  b_if.pass_cnt, 3);
        chk("t2_b_fail",  b_if.fail_cnt, 1);
        chk("t2_b_idx",   b_if.err_idx, 1);
        chk("t2_b_code",  b_if.err_code, 2'b01);
        chk("t2_b_empty", b_if.empty, 1);
        chk("t2_b_issued", b_iss - bb, 4);
        rsp_tab[1] = 8'hA5;

        // ---- abort in IDLE flushes silently; start on empty pulses done only
        d0 = a_done;
        flush();
        chk("t3_flush_empty", a_if.empty, 1);
        chk("t3_flush_nodone", a_done - d0, 0);
        pulse_start();
        chk("t3_empty_start_done", a_if.done, 1);
        chk("t3_empty_start_busy", a_if.busy, 0);
        chk("t3_keep_pass", a_if.pass_cnt, 1);
        chk("t3_keep_err",  a_if.err, 1);
        @(negedge clk);

        // ---- timeout: no response ever
        rsp_mode = 1;
        rsp_late = -1;
        push(16'h7777);
        d0 = a_done;
        pulse_start();
        chk("t4_send", a_if.send_cmd, 1);
        repeat (99) @(negedge clk);
        chk("t4_c99_fail", a_if.fail_cnt, 0);
        chk("t4_c99_err",  a_if.err, 0);
        @(negedge clk);
        chk("t4_c100_fail", a_if.fail_cnt, 1);
        chk("t4_c100_code", a_if.err_code, 2'b10);
        chk("t4_c100_idx",  a_if.err_idx, 0);
        chk("t4_b_fail",    b_if.fail_cnt, 1);
        wait_idle("t4");
        chk("t4_done", a_done - d0, 1);

        // ---- response on the last legal cycle wins over timeout
        rsp_late = 99;
        push(16'h7778);
        pulse_start();
        repeat (100) @(negedge clk);
        chk("t4b_pass", a_if.pass_cnt, 1);
        chk("t4b_fail", a_if.fail_cnt, 0);
        chk("t4b_err",  a_if.err, 0);
        wait_idle("t4b");

        // ---- overfill, then top up mid-run across the pointer wrap
        rsp_mode = 0;
        for (int i = 0; i < 18; i++) begin
            push(16'h0100 + 16'(i));
            if (i == 14) chk("t5_not_full_15", a_if.full, 0);
            if (i == 15) chk("t5_full_16", a_if.full, 1);
        end
        chk("t5_full_after", a_if.full, 1);
        base = iss_log.size();
        pulse_start();
        n = 0;
        while ((a_if.pass_cnt < 2) && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        chk("t5_pass2_bound", 32'(n < 500), 1);
        push(16'hAAA1);
        push(16'hAAA2);
        wait_idle("t5");
        chk("t5_n_issued", iss_log.size() - base, 18);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t5_cmd%0d", i), iss(base + i), 16'h0100 + 16'(i));
        end
        chk("t5_cmd16", iss(base + 16), 16'hAAA1);
        chk("t5_cmd17", iss(base + 17), 16'hAAA2);
        chk("t5_pass", a_if.pass_cnt, 18);

        // ---- abort during the 2nd command's response wait (with a colliding write)
        rsp_mode = 1;
        rsp_late = 10;
        for (int i = 1; i <= 5; i++) push(16'h0500 + 16'(i));
        base = iss_log.size();
        d0   = a_done;
        pulse_start();
        n = 0;
        while ((iss_log.size() < base + 2) && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        chk("t6_second_bound", 32'(n < 500), 1);
        repeat (5) @(negedge clk);
        abort   = 1'b1;
        wr_cmd  = 1'b1;
        wr_data = 16'hDEAD;
        @(negedge clk);
        abort  = 1'b0;
        wr_cmd = 1'b0;
        wait_idle("t6");
        chk("t6_done",  a_done - d0, 1);
        chk("t6_empty", a_if.empty, 1);
        chk("t6_pass",  a_if.pass_cnt, 1);
        repeat (30) @(negedge clk);
        chk("t6_no_more_issue", iss_log.size() - base, 2);

        // ---- asynchronous reset mid-run
        rsp_mode = 0;
        push(16'h0901); push(16'h0902); push(16'h0903);
        pulse_start();
        repeat (6) @(negedge clk);
        chk("t7_busy_pre", a_if.busy, 1);
        chk("t7_pass_pre", a_if.pass_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_busy",  a_if.busy, 0);
        chk("t7_cmd",   a_if.cmd, 0);
        chk("t7_pass",  a_if.pass_cnt, 0);
        chk("t7_empty", a_if.empty, 1);
        chk("t7_send",  a_if.send_cmd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
